// File: rtl/slap_video_mixer_if.sv
// Palette byte-write bus from the ROM-download/CPU side into the video mixer.
interface slap_video_mixer_if #(
  parameter int PAL_AW = 10
);
  logic              pal_wr;
  logic [PAL_AW:0]   pal_addr;
  logic [7:0]        pal_din;

  modport master (output pal_wr, output pal_addr, output pal_din);
  modport slave  (input  pal_wr, input  pal_addr, input  pal_din);
endinterface

// File: rtl/slap_video_mixer.sv
// Final video stage: FG > SP > BG priority merge, palette lookup and registered 4:4:4 RGB
// with blanking delayed through the same 3-stage pixel_ce pipeline.
module slap_video_mixer #(
  parameter int         PAL_AW   = 10,
  parameter logic [3:0] SP_TRANS = 4'd0,
  parameter logic [1:0] FG_TRANS = 2'd0
) (
  input  logic                     master_clk,
  input  logic                     nRESET,
  input  logic                     pixel_ce,
  input  logic                     HBLANK,
  input  logic                     VBLANK,
  input  logic [7:0]               BG_PIX,
  input  logic [7:0]               FG_PIX,
  input  logic [7:0]               SP_PIX,
  input  logic [2:0]               LAYER_EN,
  slap_video_mixer_if.slave        pal,
  output logic [3:0]               RED,
  output logic [3:0]               GREEN,
  output logic [3:0]               BLUE,
  output logic                     HBLANK_out,
  output logic                     VBLANK_out
);

  logic              fg_opaque;
  logic              sp_opaque;
  logic              bg_opaque;
  logic [PAL_AW-1:0] s1_addr_next;
  logic              s1_black_next;

  logic [PAL_AW-1:0] s1_addr_reg;
  logic              s1_black_reg;
  logic              s1_hb_reg;
  logic              s1_vb_reg;
  logic              s1_valid_reg;
  logic              s2_black_reg;
  logic              s2_hb_reg;
  logic              s2_vb_reg;
  logic              s2_valid_reg;
  logic [11:0]       rd_data_reg;
  logic [11:0]       rgb_reg;
  logic [11:0]       rgb_next;
  logic              pix_off;
  logic [7:0]        hold_lo_reg;

  logic [11:0]       pal_mem [0:(1 << PAL_AW) - 1];

  assign fg_opaque = LAYER_EN[2] && (FG_PIX[1:0] != FG_TRANS);
  assign sp_opaque = LAYER_EN[1] && (SP_PIX[3:0] != SP_TRANS);
  assign bg_opaque = LAYER_EN[0];

  always_comb begin
    s1_addr_next  = '0;
    s1_black_next = 1'b0;
    if (fg_opaque) begin
      s1_addr_next = PAL_AW'({2'b10, FG_PIX});
    end else if (sp_opaque) begin
      s1_addr_next = PAL_AW'({2'b01, SP_PIX});
    end else if (bg_opaque) begin
      s1_addr_next = PAL_AW'({2'b00, BG_PIX});
    end else begin
      s1_black_next = 1'b1;
    end
  end

  // Valid bits keep the output black/blanked until real pixels reach S3 after reset.
  assign pix_off = !s2_valid_reg || s2_hb_reg || s2_vb_reg || s2_black_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      assign rgb_next[gi*4 +: 4] = pix_off ? 4'h0 : rd_data_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge master_clk or negedge nRESET) begin
    if (!nRESET) begin
      s1_addr_reg  <= '0;
      s1_black_reg <= 1'b0;
      s1_hb_reg    <= 1'b0;
      s1_vb_reg    <= 1'b0;
      s1_valid_reg <= 1'b0;
      s2_black_reg <= 1'b0;
      s2_hb_reg    <= 1'b0;
      s2_vb_reg    <= 1'b0;
      s2_valid_reg <= 1'b0;
      rgb_reg      <= '0;
      HBLANK_out   <= 1'b1;
      VBLANK_out   <= 1'b1;
    end else if (pixel_ce) begin
      s1_addr_reg  <= s1_addr_next;
      s1_black_reg <= s1_black_next;
      s1_hb_reg    <= HBLANK;
      s1_vb_reg    <= VBLANK;
      s1_valid_reg <= 1'b1;
      s2_black_reg <= s1_black_reg;
      s2_hb_reg    <= s1_hb_reg;
      s2_vb_reg    <= s1_vb_reg;
      s2_valid_reg <= s1_valid_reg;
      rgb_reg      <= rgb_next;
      HBLANK_out   <= s2_valid_reg ? s2_hb_reg : 1'b1;
      VBLANK_out   <= s2_valid_reg ? s2_vb_reg : 1'b1;
    end
  end

  // A pending-low-byte flag would have no observable effect: odd writes always commit.
  always_ff @(posedge master_clk or negedge nRESET) begin
    if (!nRESET) begin
      hold_lo_reg <= 8'h00;
    end else if (pal.pal_wr && !pal.pal_addr[0]) begin
      hold_lo_reg <= pal.pal_din;
    end
  end

  // Read-before-write: a same-cycle commit to the entry being read returns the old word.
  always_ff @(posedge master_clk) begin
    if (pal.pal_wr && pal.pal_addr[0]) begin
      pal_mem[pal.pal_addr[PAL_AW:1]] <= {pal.pal_din[3:0], hold_lo_reg};
    end
    if (pixel_ce) begin
      rd_data_reg <= pal_mem[s1_addr_reg];
    end
  end

  assign RED   = rgb_reg[3:0];
  assign GREEN = rgb_reg[7:4];
  assign BLUE  = rgb_reg[11:8];

endmodule

// File: tb/tb_slap_video_mixer.sv
// Directed bench for slap_video_mixer: table-driven pixel stream plus reset, stall and collision sequences.
module tb_slap_video_mixer;

  logic       clk;
  logic       nreset;
  logic       pixel_ce;
  logic       hblank;
  logic       vblank;
  logic [7:0] bg_pix;
  logic [7:0] fg_pix;
  logic [7:0] sp_pix;
  logic [2:0] layer_en;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       hblank_out;
  logic       vblank_out;

  int tests_run;
  int tests_failed;

  slap_video_mixer_if #(.PAL_AW(10)) pal_bus ();

  slap_video_mixer #(.PAL_AW(10), .SP_TRANS(4'd0), .FG_TRANS(2'd0)) dut (
    .master_clk (clk),
    .nRESET     (nreset),
    .pixel_ce   (pixel_ce),
    .HBLANK     (hblank),
    .VBLANK     (vblank),
    .BG_PIX     (bg_pix),
    .FG_PIX     (fg_pix),
    .SP_PIX     (sp_pix),
    .LAYER_EN   (layer_en),
    .pal        (pal_bus),
    .RED        (red),
    .GREEN      (green),
    .BLUE       (blue),
    .HBLANK_out (hblank_out),
    .VBLANK_out (vblank_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        hb;
    logic        vb;
    logic [2:0]  en;
    logic [7:0]  fg;
    logic [7:0]  sp;
    logic [7:0]  bg;
    logic [11:0] exp_rgb;   // {R,G,B}
    logic        exp_hb;
    logic        exp_vb;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic hb, input logic vb, input logic [2:0] en,
                         input logic [7:0] fg, input logic [7:0] sp, input logic [7:0] bg,
                         input logic [11:0] exp_rgb, input logic exp_hb, input logic exp_vb);
    vec_t v;
    v.hb = hb; v.vb = vb; v.en = en; v.fg = fg; v.sp = sp; v.bg = bg;
    v.exp_rgb = exp_rgb; v.exp_hb = exp_hb; v.exp_vb = exp_vb;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [11:0] exp_rgb,
                       input logic exp_hb, input logic exp_vb);
    logic [11:0] got;
    got = {red, green, blue};
    tests_run++;
    if (got !== exp_rgb || hblank_out !== exp_hb || vblank_out !== exp_vb) begin
      tests_failed++;
      $display("FAIL %s: got rgb=%h hb=%b vb=%b, expected rgb=%h hb=%b vb=%b",
               name, got, hblank_out, vblank_out, exp_rgb, exp_hb, exp_vb);
    end else begin
      $display("[TB] ok %s rgb=%h hb=%b vb=%b", name, got, hblank_out, vblank_out);
    end
  endtask

  task automatic drive(input logic hb, input logic vb, input logic [2:0] en,
                       input logic [7:0] fg, input logic [7:0] sp, input logic [7:0] bg);
    hblank = hb; vblank = vb; layer_en = en; fg_pix = fg; sp_pix = sp; bg_pix = bg;
  endtask

  // One pixel_ce pulse, optionally with a palette byte write on the same edge.
  task automatic ce_step(input logic do_wr, input logic [10:0] addr, input logic [7:0] din);
    pixel_ce         = 1'b1;
    pal_bus.pal_wr   = do_wr;
    pal_bus.pal_addr = addr;
    pal_bus.pal_din  = din;
    @(posedge clk);
    #1;
    pixel_ce       = 1'b0;
    pal_bus.pal_wr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic pal_write(input logic [10:0] addr, input logic [7:0] din);
    pal_bus.pal_wr   = 1'b1;
    pal_bus.pal_addr = addr;
    pal_bus.pal_din  = din;
    @(posedge clk);
    #1;
    pal_bus.pal_wr = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    nreset       = 1'b0;
    pixel_ce     = 1'b0;
    pal_bus.pal_wr   = 1'b0;
    pal_bus.pal_addr = '0;
    pal_bus.pal_din  = '0;
    drive(1'b0, 1'b0, 3'b111, 8'h00, 8'h00, 8'h11);

    @(posedge clk);
    #1;
    check("reset_state", 12'h000, 1'b1, 1'b1);
    #3 nreset = 1'b1;

    // Palette: entry 0x011=123, 0x102=A5C, 0x241=564, 0x137=789, 0x080=ABD (RGB)
    pal_write(11'h022, 8'h21); pal_write(11'h023, 8'h03);
    pal_write(11'h204, 8'h5A); pal_write(11'h205, 8'h0C);
    pal_write(11'h482, 8'h65); pal_write(11'h483, 8'hF4);
    pal_write(11'h26E, 8'h87); pal_write(11'h26F, 8'h09);
    pal_write(11'h100, 8'hBA); pal_write(11'h101, 8'h0D);

    //       hb    vb    en      fg     sp     bg     exp     ehb   evb
    add_vec(1'b0, 1'b0, 3'b111, 8'h00, 8'h00, 8'h11, 12'h123, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 3'b111, 8'h00, 8'h02, 8'h11, 12'hA5C, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 3'b111, 8'h41, 8'h37, 8'h80, 12'h564, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 3'b111, 8'h40, 8'h37, 8'h80, 12'h789, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 3'b111, 8'h40, 8'h30, 8'h80, 12'hABD, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 3'b000, 8'h41, 8'h37, 8'h80, 12'h000, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 3'b011, 8'h41, 8'h37, 8'h80, 12'h789, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 3'b100, 8'h40, 8'h37, 8'h80, 12'h000, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 3'b101, 8'h40, 8'h37, 8'h80, 12'hABD, 1'b0, 1'b0);
    add_vec(1'b1, 1'b0, 3'b111, 8'h41, 8'h37, 8'h80, 12'h000, 1'b1, 1'b0);
    add_vec(1'b0, 1'b1, 3'b111, 8'h41, 8'h37, 8'h80, 12'h000, 1'b0, 1'b1);
    add_vec(1'b0, 1'b0, 3'b111, 8'h00, 8'h00, 8'h11, 12'h123, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++)
      add_vec(1'b1, 1'b0, 3'b111, 8'h00, 8'h00, 8'h11, 12'h000, 1'b1, 1'b0);
    add_vec(1'b0, 1'b0, 3'b111, 8'h00, 8'h00, 8'h11, 12'h123, 1'b0, 1'b0);

    // Stream: output after the i-th pixel_ce belongs to vector i-2.
    for (int i = 0; i < vecs.size() + 2; i++) begin
      int j;
      j = (i < vecs.size()) ? i : vecs.size() - 1;
      drive(vecs[j].hb, vecs[j].vb, vecs[j].en, vecs[j].fg, vecs[j].sp, vecs[j].bg);
      ce_step(1'b0, 11'h000, 8'h00);
      if (i >= 2)
        check($sformatf("vec%0d", i - 2), vecs[i-2].exp_rgb, vecs[i-2].exp_hb, vecs[i-2].exp_vb);
    end

    // Reset mid-stream: asynchronous clear, then 3 pixel_ce to first real pixel.
    drive(1'b0, 1'b0, 3'b111, 8'h41, 8'h37, 8'h80);
    #3 nreset = 1'b0;
    #1 check("rst_async", 12'h000, 1'b1, 1'b1);
    ce_step(1'b0, 11'h000, 8'h00);
    check("rst_held", 12'h000, 1'b1, 1'b1);
    #2 nreset = 1'b1;
    drive(1'b0, 1'b0, 3'b111, 8'h00, 8'h00, 8'h11);
    ce_step(1'b0, 11'h000, 8'h00);
    check("rst_rel_ce1", 12'h000, 1'b1, 1'b1);
    ce_step(1'b0, 11'h000, 8'h00);
    check("rst_rel_ce2", 12'h000, 1'b1, 1'b1);
    ce_step(1'b0, 11'h000, 8'h00);
    check("rst_rel_ce3", 12'h123, 1'b0, 1'b0);

    // Odd write straight after reset uses the cleared low byte.
    pal_write(11'h023, 8'h07);
    for (int k = 0; k < 3; k++) ce_step(1'b0, 11'h000, 8'h00);
    check("odd_no_hold", 12'h007, 1'b0, 1'b0);

    // Second even write overwrites the first; high nibble of odd byte ignored.
    pal_write(11'h022, 8'hFF);
    pal_write(11'h022, 8'h21);
    pal_write(11'h023, 8'hF3);
    for (int k = 0; k < 3; k++) ce_step(1'b0, 11'h000, 8'h00);
    check("even_twice", 12'h123, 1'b0, 1'b0);

    // Stall: pixels A,B,C then 10 cycles without pixel_ce, then D.
    drive(1'b0, 1'b0, 3'b111, 8'h00, 8'h00, 8'h11); ce_step(1'b0, 11'h000, 8'h00);
    drive(1'b0, 1'b0, 3'b111, 8'h00, 8'h02, 8'h11); ce_step(1'b0, 11'h000, 8'h00);
    drive(1'b0, 1'b0, 3'b111, 8'h41, 8'h37, 8'h80); ce_step(1'b0, 11'h000, 8'h00);
    check("stall_pre", 12'h123, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 3'b000, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 0 || k == 9) check($sformatf("stall_hold%0d", k), 12'h123, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 3'b111, 8'h40, 8'h30, 8'h80);
    ce_step(1'b0, 11'h000, 8'h00);
    check("stall_resume_b", 12'hA5C, 1'b0, 1'b0);
    ce_step(1'b0, 11'h000, 8'h00);
    check("stall_resume_c", 12'h564, 1'b0, 1'b0);
    ce_step(1'b0, 11'h000, 8'h00);
    check("stall_resume_d", 12'hABD, 1'b0, 1'b0);

    // Collision: commit to entry 0x011 on the edge S2 reads it.
    drive(1'b0, 1'b0, 3'b111, 8'h00, 8'h00, 8'h11);
    ce_step(1'b0, 11'h000, 8'h00);
    pal_write(11'h022, 8'h54);
    ce_step(1'b1, 11'h023, 8'h06);
    ce_step(1'b0, 11'h000, 8'h00);
    check("collide_old", 12'h123, 1'b0, 1'b0);
    ce_step(1'b0, 11'h000, 8'h00);
    check("collide_new", 12'h456, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
